// File: rtl/hi_term_router.sv
// Host-to-terminal router: decodes the host terminal address once per transaction,
// forwards host traffic to the matching device port, answers unmatched transactions
// locally and aborts transactions whose device stalls for too long.
module hi_term_router #(
  parameter int unsigned               NUM_TERMS  = 2,
  parameter logic [16*NUM_TERMS-1:0]   TERM_ADDRS = {16'h0001, 16'h0000},
  parameter int unsigned               TIMEOUT    = 1024
) (
  input  logic                      ifclk,
  input  logic                      resetb,
  input  logic [15:0]               di_term_addr,
  input  logic [31:0]               di_reg_addr,
  input  logic [31:0]               di_len,
  input  logic                      di_read_mode,
  input  logic                      di_read_req,
  input  logic                      di_read,
  input  logic                      di_write_mode,
  input  logic                      di_write,
  input  logic [31:0]               di_reg_datai,
  output logic                      di_read_rdy,
  output logic                      di_write_rdy,
  output logic [31:0]               di_reg_datao,
  output logic [15:0]               di_transfer_status,
  output logic [16*NUM_TERMS-1:0]   T_di_term_addr,
  output logic [32*NUM_TERMS-1:0]   T_di_reg_addr,
  output logic [32*NUM_TERMS-1:0]   T_di_len,
  output logic [32*NUM_TERMS-1:0]   T_di_reg_datai,
  output logic [NUM_TERMS-1:0]      T_di_read_mode,
  output logic [NUM_TERMS-1:0]      T_di_read_req,
  output logic [NUM_TERMS-1:0]      T_di_read,
  output logic [NUM_TERMS-1:0]      T_di_write_mode,
  output logic [NUM_TERMS-1:0]      T_di_write,
  input  logic [NUM_TERMS-1:0]      T_di_read_rdy,
  input  logic [NUM_TERMS-1:0]      T_di_write_rdy,
  input  logic [32*NUM_TERMS-1:0]   T_di_reg_datao,
  input  logic [16*NUM_TERMS-1:0]   T_di_transfer_status,
  output logic                      timeout_err
);

  localparam int unsigned SelW = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StRoute, StNoMatch, StTimeout} state_e;

  state_e          state_q;
  logic [SelW-1:0] sel_q;
  logic            pend_req_q;
  logic [CntW-1:0] cnt_q;
  logic            timeout_err_q;

  logic            any_mode;
  logic            match_hit;
  logic [SelW-1:0] match_idx;
  logic            sel_rrdy;
  logic            sel_wrdy;
  logic            stall;

  assign any_mode    = di_read_mode | di_write_mode;
  assign timeout_err = timeout_err_q;

  // Address decode: descending scan so the lowest matching port wins.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int k = int'(NUM_TERMS) - 1; k >= 0; k--) begin
      if (TERM_ADDRS[16*k +: 16] == di_term_addr) begin
        match_hit = 1'b1;
        match_idx = SelW'(k);
      end
    end
  end

  // Readiness of the selected port and the resulting stall condition.
  always_comb begin
    sel_rrdy = 1'b0;
    sel_wrdy = 1'b0;
    for (int k = 0; k < int'(NUM_TERMS); k++) begin
      if (sel_q == SelW'(k)) begin
        sel_rrdy = T_di_read_rdy[k];
        sel_wrdy = T_di_write_rdy[k];
      end
    end
    stall = (di_write_mode & ~sel_wrdy) | (di_read_mode & ~sel_rrdy);
  end

  // Transaction sequencing, port selection, read-request replay and stall timeout.
  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      state_q       <= StIdle;
      sel_q         <= '0;
      pend_req_q    <= 1'b0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (any_mode) begin
            timeout_err_q <= 1'b0;
            if (match_hit) begin
              state_q    <= StRoute;
              sel_q      <= match_idx;
              pend_req_q <= di_read_req;
            end else begin
              state_q <= StNoMatch;
            end
          end
        end
        StRoute: begin
          pend_req_q <= 1'b0;
          if (!any_mode) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (stall) begin
            cnt_q <= cnt_q + 1'b1;
            // This increment makes the counter reach TIMEOUT.
            if (cnt_q == CntW'(TIMEOUT - 1)) begin
              state_q       <= StTimeout;
              timeout_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= '0;
          end
        end
        StNoMatch, StTimeout: begin
          if (!any_mode) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Port fan-out and host response mux; everything idles at zero outside a transaction.
  always_comb begin
    T_di_term_addr     = '0;
    T_di_reg_addr      = '0;
    T_di_len           = '0;
    T_di_reg_datai     = '0;
    T_di_read_mode     = '0;
    T_di_read_req      = '0;
    T_di_read          = '0;
    T_di_write_mode    = '0;
    T_di_write         = '0;
    di_read_rdy        = 1'b0;
    di_write_rdy       = 1'b0;
    di_reg_datao       = '0;
    di_transfer_status = '0;
    if (state_q == StRoute || state_q == StTimeout) begin
      for (int k = 0; k < int'(NUM_TERMS); k++) begin
        if (sel_q == SelW'(k)) begin
          T_di_term_addr[16*k +: 16] = di_term_addr;
          T_di_reg_addr[32*k +: 32]  = di_reg_addr;
          T_di_len[32*k +: 32]       = di_len;
          T_di_reg_datai[32*k +: 32] = di_reg_datai;
          T_di_read_req[k]           = di_read_req | pend_req_q;
          T_di_read[k]               = di_read;
          T_di_write[k]              = di_write;
          // Modes drop in the timeout state so the device abandons the transfer.
          if (state_q == StRoute) begin
            T_di_read_mode[k]  = di_read_mode;
            T_di_write_mode[k] = di_write_mode;
            di_read_rdy        = T_di_read_rdy[k];
            di_write_rdy       = T_di_write_rdy[k];
            di_reg_datao       = T_di_reg_datao[32*k +: 32];
            di_transfer_status = T_di_transfer_status[16*k +: 16];
          end
        end
      end
    end
    if (state_q == StNoMatch || state_q == StTimeout) begin
      di_read_rdy        = 1'b1;
      di_write_rdy       = 1'b1;
      di_reg_datao       = 32'hDEADBEEF;
      di_transfer_status = (state_q == StTimeout) ? 16'h0002 : 16'h0001;
    end
  end

endmodule

// File: doc/hi_term_router.md
HI_TERM_ROUTER -- requirements
Module: hi_term_router

Interface
REQ-001 Parameter NUM_TERMS, default 2: number of device-side terminal ports.
REQ-002 Parameter TERM_ADDRS, default {16'h0001,16'h0000}: packed 16*NUM_TERMS terminal addresses; slice k is port k.
REQ-003 Parameter TIMEOUT, default 1024: maximum consecutive not-ready cycles before the router fakes completion.
REQ-004 Ports (name  direction  width  meaning):
- ifclk  in  1  clock.
- resetb  in  1  reset: asynchronous, active-low.
- di_term_addr  in  16  host terminal address.
- di_reg_addr, di_len  in  32 each  host register address and transfer length.
- di_read_mode, di_read_req, di_read  in  1 each  host read controls.
- di_write_mode, di_write  in  1 each  host write controls.
- di_reg_datai  in  32  host write data.
- di_read_rdy, di_write_rdy  out  1 each  returned readiness.
- di_reg_datao  out  32  returned read data.
- di_transfer_status  out  16  returned status.
- T_di_term_addr  out  16*NUM_TERMS  per-port copy of di_term_addr.
- T_di_reg_addr, T_di_len, T_di_reg_datai  out  32*NUM_TERMS each  per-port copies.
- T_di_read_mode, T_di_read_req, T_di_read, T_di_write_mode, T_di_write  out  NUM_TERMS each  per-port controls.
- T_di_read_rdy, T_di_write_rdy  in  NUM_TERMS each  per-port readiness.
- T_di_reg_datao  in  32*NUM_TERMS  per-port read data.
- T_di_transfer_status  in  16*NUM_TERMS  per-port status.
- timeout_err  out  1  sticky: last transaction timed out.

Function
REQ-005 States: IDLE, ROUTE, NOMATCH, TIMEOUT; registered state and registered select index sel.
REQ-006 IDLE: all T_di_* outputs are 0; di_read_rdy=0, di_write_rdy=0, di_reg_datao=0, di_transfer_status=0.
REQ-007 IDLE with di_read_mode or di_write_mode high: compare di_term_addr against every TERM_ADDRS slice; lowest matching index loads sel and the next state is ROUTE; no match gives next state NOMATCH.
REQ-008 Leaving IDLE clears timeout_err.
REQ-009 A di_read_req seen during the IDLE decode cycle is captured in pend_req and replayed as a one-cycle T_di_read_req[sel] pulse in the first ROUTE cycle; pend_req then clears.
REQ-010 ROUTE: port sel carries all host inputs combinationally (OR of pend_req onto read_req); the other ports are held at 0; host outputs mirror port sel inputs.
REQ-011 sel is held for the whole transaction; di_term_addr changes after decode are ignored.
REQ-012 ROUTE with di_read_mode and di_write_mode both low: next state IDLE.
REQ-013 NOMATCH: all ports at 0; di_write_rdy=1 and written words are discarded; di_read_rdy=1; di_reg_datao=32'hDEADBEEF; di_transfer_status=16'h0001.
REQ-014 NOMATCH with both modes low: next state IDLE.
REQ-015 Timeout counter (width clog2(TIMEOUT+1)) runs only in ROUTE and is cleared on entry to ROUTE.
REQ-016 Counter increments each cycle in which (di_write_mode and !T_di_write_rdy[sel]) or (di_read_mode and !T_di_read_rdy[sel]); any cycle not meeting this clears it.
REQ-017 Counter reaching TIMEOUT sets timeout_err and moves ROUTE to TIMEOUT the next cycle.
REQ-018 TIMEOUT: port sel modes forced to 0 so the device aborts; host sees NOMATCH responses except di_transfer_status=16'h0002; both modes low gives next state IDLE.
REQ-019 Both modes high together are both forwarded; the router does not arbitrate direction.

Reset
REQ-020 resetb low asynchronously forces: state=IDLE, sel=0, pend_req=0, counter=0, timeout_err=0, and all outputs to the IDLE values of REQ-006.
REQ-021 Reset mid-transaction drops the transaction; no replay after reset is released.

Verification
REQ-022 Write to term 16'h0001, 4 words, port 1 always ready -> port 1 sees 4 di_write pulses with matching data; port 0 stays all-zero; status mirrors port 1.
REQ-023 Read from term 16'h0000 with di_read_req in the mode-rise cycle -> exactly one T_di_read_req[0] pulse one cycle later; di_reg_datao equals port 0 data.
REQ-024 Read from term 16'h0005 (unmatched) -> di_read_rdy=1, data 32'hDEADBEEF, status 16'h0001; no port activity.
REQ-025 Write to port 0 with T_di_write_rdy[0] held 0, TIMEOUT=8 -> TIMEOUT entered after 8 stalled cycles; timeout_err=1; status 16'h0002; timeout_err clears at the next transaction start.
REQ-026 di_term_addr changed from 0 to 1 mid-transaction -> traffic stays on port 0 until both modes fall.
REQ-027 resetb pulsed low during ROUTE -> all outputs 0 immediately; state IDLE; next transaction decodes normally.
